// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin arbiter funnelling NUM_REQ write requesters into one
//            FIFO write port, with full-aware back-pressure and drop counting.
// Revision : 1.0
// ============================================================================
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          fifo_full,
  input  logic                          fifo_almostfull,
  input  logic                          fifo_overflow,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          stall,
  output logic [7:0]                    drop_count
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_PTR_W-1:0]        r_ptr;
  logic [NUM_REQ-1:0]        r_gnt;
  logic                      r_wr_en;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [7:0]                r_drop;

  logic [2*NUM_REQ-1:0]      w_rot;
  logic                      w_any_req;
  logic                      w_permit;
  logic                      w_grant;
  logic [c_PTR_W-1:0]        w_ofs;
  logic [c_PTR_W:0]          w_sum;
  logic [c_PTR_W-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]        w_win_oh;
  logic [DATA_WIDTH-1:0]     w_win_data;
  logic [c_PTR_W-1:0]        w_ptr_nxt;

  // Low half of w_rot is req rotated so bit k is requester (ptr+k) mod NUM_REQ;
  // the upper half only holds copies of req bits, so OR-ing it all is |req.
  assign w_rot     = {req, req} >> r_ptr;
  assign w_any_req = |w_rot;

  // The write already on the bus lands next edge, so almost-full must block.
  assign w_permit  = !fifo_full && !(fifo_almostfull && r_wr_en);
  assign w_grant   = w_permit && w_any_req;

  always_comb begin
    w_ofs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_ofs = c_PTR_W'(k);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, w_ofs};
    if (w_sum >= (c_PTR_W + 1)'(NUM_REQ)) begin
      w_sum = w_sum - (c_PTR_W + 1)'(NUM_REQ);
    end
  end

  assign w_win_idx = w_sum[c_PTR_W-1:0];
  assign w_win_oh  = NUM_REQ'(1) << w_win_idx;
  assign w_ptr_nxt = (w_win_idx == c_PTR_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_idx == c_PTR_W'(i)) begin
        w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = ST_IDLE;
    if (w_any_req) begin
      w_state_nxt = w_permit ? ST_ARB : ST_STALL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_wr_en <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wr_en <= w_grant;
      r_gnt   <= w_grant ? w_win_oh : '0;
      if (w_grant) begin
        r_data <= w_win_data;
        r_ptr  <= w_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop <= 8'd0;
    end else if (fifo_overflow && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign gnt          = r_gnt;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;
  assign stall        = (r_state == ST_STALL);
  assign drop_count   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Self-checking bench: directed vector table, drop-count saturation,
//            asynchronous reset, and randomized run against a reference model.
// Revision : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic            full, afull, ovf;
  logic [N-1:0]    gnt;
  logic            wr_en;
  logic [DW-1:0]   dout;
  logic            stall;
  logic [7:0]      drop;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .fifo_full(full), .fifo_almostfull(afull), .fifo_overflow(ovf),
    .gnt(gnt), .fifo_wr_en(wr_en), .fifo_data_in(dout),
    .stall(stall), .drop_count(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arbitration expressed as a modulo search from a pointer.
  int            m_ptr;
  logic [N-1:0]  m_gnt;
  logic          m_wr;
  logic [DW-1:0] m_data;
  logic          m_stall;
  int            m_drop;
  logic [DW-1:0] exp_q[$];

  task automatic model_reset();
    m_ptr = 0; m_gnt = '0; m_wr = 1'b0; m_data = '0; m_stall = 1'b0; m_drop = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit perm;
    bit any;
    int w;
    perm = !full && !(afull && m_wr);
    any  = (req != '0);
    m_stall = any && !perm;
    if (any && perm) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      m_gnt    = '0;
      m_gnt[w] = 1'b1;
      m_wr     = 1'b1;
      m_data   = req_data[w*DW +: DW];
      exp_q.push_back(m_data);
      m_ptr    = (w + 1) % N;
    end else begin
      m_gnt = '0;
      m_wr  = 1'b0;
    end
    if (ovf && m_drop < 255) m_drop++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"},   32'(gnt),   32'(m_gnt));
    chk({tag, ".wr_en"}, 32'(wr_en), 32'(m_wr));
    chk({tag, ".data"},  32'(dout),  32'(m_data));
    chk({tag, ".stall"}, 32'(stall), 32'(m_stall));
    chk({tag, ".drop"},  32'(drop),  32'(m_drop));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; full = 1'b0; afull = 1'b0; ovf = 1'b0;
    @(negedge clk);
    chk("rst.gnt",   32'(gnt),   0);
    chk("rst.wr_en", 32'(wr_en), 0);
    chk("rst.data",  32'(dout),  0);
    chk("rst.stall", 32'(stall), 0);
    chk("rst.drop",  32'(drop),  0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic          full;
    logic          afull;
    logic [N-1:0]  gnt;
    logic          wr;
    logic [DW-1:0] data;
    logic          stall;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cnt;
    bit pending;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] exp_word;

    rst = 1'b1; req = '0; req_data = '0; full = 1'b0; afull = 1'b0; ovf = 1'b0;

    // Rotation, alternating pair, almost-full/full blocking, single requester.
    tbl[0]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 16'h10, 1'b0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h11, 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 16'h12, 1'b0};
    tbl[3]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 16'h13, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 16'h10, 1'b0};
    tbl[5]  = '{4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 16'h12, 1'b0};
    tbl[6]  = '{4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 16'h10, 1'b0};
    tbl[7]  = '{4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 16'h12, 1'b0};
    tbl[8]  = '{4'b0101, 1'b0, 1'b1, 4'b0000, 1'b0, 16'h12, 1'b1};
    tbl[9]  = '{4'b0101, 1'b0, 1'b1, 4'b0001, 1'b1, 16'h10, 1'b0};
    tbl[10] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h10, 1'b1};
    tbl[11] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h10, 1'b1};
    tbl[12] = '{4'b0101, 1'b1, 1'b0, 4'b0000, 1'b0, 16'h10, 1'b1};
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 16'h10, 1'b0};
    tbl[14] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h11, 1'b0};
    tbl[15] = '{4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 16'h11, 1'b0};

    do_reset();
    req_data = {16'h13, 16'h12, 16'h11, 16'h10};
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; full = tbl[i].full; afull = tbl[i].afull; ovf = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d.gnt", i),   32'(gnt),   32'(tbl[i].gnt));
      chk($sformatf("vec%0d.wr_en", i), 32'(wr_en), 32'(tbl[i].wr));
      chk($sformatf("vec%0d.data", i),  32'(dout),  32'(tbl[i].data));
      chk($sformatf("vec%0d.stall", i), 32'(stall), 32'(tbl[i].stall));
    end

    // Drop counter saturation.
    req = '0; full = 1'b0; afull = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ovf = 1'b1;
      @(negedge clk);
      if (i == 99) chk("drop.at100", 32'(drop), 100);
    end
    chk("drop.sat", 32'(drop), 255);
    ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("drop.hold", 32'(drop), 255);

    // Asynchronous reset mid-grant, then pointer restart.
    do_reset();
    req_data = {16'hD3, 16'hD2, 16'hD1, 16'hD0};
    req = 4'b0010;
    @(negedge clk);
    chk("arst.pre.wr_en", 32'(wr_en), 1);
    chk("arst.pre.gnt",   32'(gnt),   32'(4'b0010));
    #2 rst = 1'b1;
    #1;
    chk("arst.wr_en", 32'(wr_en), 0);
    chk("arst.gnt",   32'(gnt),   0);
    chk("arst.data",  32'(dout),  0);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    @(negedge clk);
    chk("arst.post.gnt",  32'(gnt),  32'(4'b0010));
    chk("arst.post.data", 32'(dout), 32'h00D1);

    // Randomized run against the model with a modelled FIFO draining slowly.
    do_reset();
    cnt = 0; pending = 1'b0; pend_data = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (pending) begin
        chk("fifo.overrun", 32'(cnt >= DEPTH), 0);
        if (cnt < DEPTH) cnt++;
        if (exp_q.size() == 0) begin
          chk("sb.underflow", 1, 0);
        end else begin
          exp_word = exp_q.pop_front();
          chk("sb.data", 32'(pend_data), 32'(exp_word));
        end
      end
      if (cnt > 0 && $urandom_range(0, 2) == 0) cnt--;
      full     = (cnt == DEPTH);
      afull    = (cnt == DEPTH - 1);
      req      = N'($urandom);
      req_data = {$urandom, $urandom};
      ovf      = ($urandom_range(0, 15) == 0);
      model_step();
      @(negedge clk);
      check_model($sformatf("rnd%0d", cyc));
      chk("wr_after_full", 32'(wr_en && full), 0);
      pending   = wr_en;
      pend_data = dout;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, FIFO word width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester write request; bit i held high while requester i has a word pending.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed words; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-008 SHALL have port fifo_almostfull  input  1  FIFO one-slot-left flag.
REQ-009 SHALL have port fifo_overflow  input  1  FIFO rejected-write pulse.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse; requester i's word is being written this cycle.
REQ-011 SHALL have port fifo_wr_en  output  1  FIFO write enable.
REQ-012 SHALL have port fifo_data_in  output  DATA_WIDTH  FIFO write data.
REQ-013 SHALL have port stall  output  1  high while requests are pending but blocked by FIFO fullness.
REQ-014 SHALL have port drop_count  output  8  saturating count of fifo_overflow pulses.

Function
REQ-015 SHALL implement FSM IDLE/ARB/STALL: IDLE when req==0; ARB when req!=0 and grant permitted; STALL when req!=0 and grant blocked.
REQ-016 Grant permitted SHALL be: !fifo_full && !(fifo_almostfull && fifo_wr_en), so an in-flight write never over-fills the FIFO.
REQ-017 On a posedge where grant is permitted and req!=0, SHALL register: gnt = one-hot winner, fifo_wr_en=1, fifo_data_in=req_data slice of winner; all three valid the following cycle (1-cycle latency).
REQ-018 On a posedge with no grant, SHALL register gnt=0, fifo_wr_en=0; fifo_data_in holds its previous value.
REQ-019 Winner SHALL be chosen round-robin: search starts at pointer ptr and wraps from NUM_REQ-1 to 0; first requester with req=1 wins.
REQ-020 After a grant to index w, ptr SHALL become (w+1) mod NUM_REQ; ptr unchanged when no grant.
REQ-021 Requester SHALL be considered served by gnt; arbiter does not mask req, so a requester that keeps req high after gnt re-enters arbitration at its next round-robin turn.
REQ-022 Back-to-back grants SHALL be allowed every cycle while permitted (throughput 1 word/cycle).
REQ-023 stall SHALL be registered: 1 in the cycle after a posedge in which req!=0 and grant was blocked, else 0.
REQ-024 drop_count SHALL increment by 1 on each posedge with fifo_overflow=1, saturating at 255.
REQ-025 fifo_overflow and a new grant in the same cycle SHALL both take effect independently.
REQ-026 With a single requester active, it SHALL be granted every permitted cycle regardless of ptr.

Reset
REQ-027 While rst=1 (asynchronous assert): gnt=0, fifo_wr_en=0, fifo_data_in=0, stall=0, drop_count=0, ptr=0, FSM=IDLE.
REQ-028 Reset asserted mid-grant SHALL drop fifo_wr_en immediately without waiting for clk; first grant after release follows ptr=0.
REQ-029 Release of rst SHALL be synchronous to clk; no grant issued in the cycle rst deasserts.

Verification
REQ-030 req=4'b1111, data_i=16'h10+i, FIFO empty -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; fifo_data_in 0x10,0x11,0x12,0x13,0x10.
REQ-031 req=4'b0101, ptr=1 -> gnt 0100 then 0001 alternating; never 0010 or 1000.
REQ-032 fifo_almostfull=1 with fifo_wr_en=1 and req!=0 -> next cycle gnt=0, fifo_wr_en=0, stall=1; fifo_full=1 held 3 cycles -> stall=1 all 3, no writes.
REQ-033 fifo_overflow pulsed 300 times -> drop_count=255 and stays 255.
REQ-034 rst asserted between clock edges during req=4'b0010 granting -> fifo_wr_en and gnt fall to 0 before next posedge; after release, req=4'b1010 -> first gnt 0010.
REQ-035 Random req/full stimulus (>=10k cycles) -> scoreboard of FIFO contents matches granted words in order; fifo_wr_en never 1 in a cycle following fifo_full=1.
